counter_display_unit: RTL and testbench

COUNTER_DISPLAY_UNIT -- requirements
Module: counter_display_unit

---
 rtl/counter_display_unit.sv | 196 +++++++++++++++++++
 tb/tb_counter_display_unit.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/counter_display_unit.sv
// Debounced up/down counter with load, sequential double-dabble BCD conversion
// and a multiplexed active-low seven-segment scan driver.
module counter_display_unit #(
  parameter int BITS      = 8,
  parameter int DIGITS    = 3,
  parameter int SATURATE  = 0,
  parameter int DB_CYCLES = 1000000,
  parameter int REFRESH   = 100000,
  parameter int LZB       = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic            up,
  input  logic            down,
  input  logic [BITS-1:0] SW,
  output logic [BITS-1:0] count,
  output logic            busy,
  output logic [6:0]      sseg,
  output logic [7:0]      AN,
  output logic            DP
);

  localparam int DBW = $clog2(DB_CYCLES + 1);
  localparam int RW  = $clog2(REFRESH + 1);
  localparam int IW  = $clog2(DIGITS + 1);
  localparam int CW  = $clog2(BITS + 1);
  localparam int BW  = 4 * DIGITS;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  function automatic logic [BITS-1:0] step(input logic [BITS-1:0] v, input logic inc);
    if (inc) begin
      if (v == '1) return (SATURATE != 0) ? v : '0;
      return v + 1'b1;
    end
    if (v == '0) return (SATURATE != 0) ? v : '1;
    return v - 1'b1;
  endfunction

  function automatic logic [BW-1:0] add3(input logic [BW-1:0] b);
    logic [BW-1:0] r;
    r = b;
    for (int k = 0; k < DIGITS; k++)
      if (r[4*k +: 4] >= 4'd5) r[4*k +: 4] = r[4*k +: 4] + 4'd3;
    return r;
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  logic [1:0]      s0_q, s1_q, lvl_q, lvl_d, pulse_q, pulse_d;
  logic [DBW-1:0]  db_cnt_q [2];
  logic [DBW-1:0]  db_cnt_d [2];
  logic [BITS-1:0] count_q, count_d, last_q, last_d, bin_q, bin_d;
  logic [BW-1:0]   bcd_q, bcd_d, disp_q, disp_d;
  logic [CW-1:0]   bit_cnt_q, bit_cnt_d;
  state_t          state_q, state_d;
  logic            busy_q, busy_d;
  logic [RW-1:0]   ref_q, ref_d;
  logic [IW-1:0]   idx_q, idx_d;

  // Debounce: index 0 is up, index 1 is down; a pulse fires when a high level is accepted
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      lvl_d[i]    = lvl_q[i];
      db_cnt_d[i] = '0;
      pulse_d[i]  = 1'b0;
      if (s1_q[i] != lvl_q[i]) begin
        if (db_cnt_q[i] == DBW'(DB_CYCLES - 1)) begin
          lvl_d[i]   = s1_q[i];
          pulse_d[i] = s1_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    count_d = count_q;
    if (load)                        count_d = SW;
    else if (pulse_q[0] ^ pulse_q[1]) count_d = step(count_q, pulse_q[0]);
  end

  always_comb begin
    state_d   = state_q;
    bin_d     = bin_q;
    bcd_d     = bcd_q;
    bit_cnt_d = bit_cnt_q;
    last_d    = last_q;
    disp_d    = disp_q;
    busy_d    = busy_q;
    case (state_q)
      IDLE: if (count_q != last_q) begin
        last_d    = count_q;
        bin_d     = count_q;
        bcd_d     = '0;
        bit_cnt_d = '0;
        busy_d    = 1'b1;
        state_d   = SHIFT;
      end
      SHIFT: begin
        {bcd_d, bin_d} = {add3(bcd_q), bin_q} << 1;
        bit_cnt_d      = bit_cnt_q + 1'b1;
        if (bit_cnt_q == CW'(BITS - 1)) state_d = DONE;
      end
      DONE: begin
        disp_d  = bcd_q;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ref_d = ref_q + 1'b1;
    idx_d = idx_q;
    if (ref_q == RW'(REFRESH - 1)) begin
      ref_d = '0;
      idx_d = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s0_q      <= '0;
      s1_q      <= '0;
      lvl_q     <= '0;
      pulse_q   <= '0;
      db_cnt_q  <= '{default: '0};
      count_q   <= '0;
      state_q   <= IDLE;
      bin_q     <= '0;
      bcd_q     <= '0;
      bit_cnt_q <= '0;
      last_q    <= '0;
      disp_q    <= '0;
      busy_q    <= 1'b0;
      ref_q     <= '0;
      idx_q     <= '0;
    end else begin
      s0_q      <= {down, up};
      s1_q      <= s0_q;
      lvl_q     <= lvl_d;
      pulse_q   <= pulse_d;
      db_cnt_q  <= db_cnt_d;
      count_q   <= count_d;
      state_q   <= state_d;
      bin_q     <= bin_d;
      bcd_q     <= bcd_d;
      bit_cnt_q <= bit_cnt_d;
      last_q    <= last_d;
      disp_q    <= disp_d;
      busy_q    <= busy_d;
      ref_q     <= ref_d;
      idx_q     <= idx_d;
    end
  end

  // Scan output: digit k>0 blanks when it and everything above it is zero
  logic [3:0] nib;
  logic       hi_zero;
  always_comb begin
    nib     = '0;
    hi_zero = 1'b0;
    AN      = 8'hFF;
    for (int k = 0; k < DIGITS; k++) begin
      if (idx_q == IW'(k)) begin
        nib     = disp_q[4*k +: 4];
        hi_zero = ((disp_q >> (4*k)) == '0);
        AN[k]   = 1'b0;
      end
    end
    sseg = ((LZB != 0) && (idx_q != '0) && hi_zero) ? 7'b1111111 : seg7(nib);
  end

  assign count = count_q;
  assign busy  = busy_q;
  assign DP    = 1'b1;

endmodule

// File: tb/tb_counter_display_unit.sv
// Directed bench for counter_display_unit: a wrapping and a saturating instance
// driven by shared stimulus, checked against hand-computed values.
module tb_counter_display_unit;

  localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100,
                         S3 = 7'b0110000, S4 = 7'b0011001, S5 = 7'b0010010,
                         S6 = 7'b0000010, S7 = 7'b1111000, S8 = 7'b0000000,
                         S9 = 7'b0010000, SB = 7'b1111111;

  logic       clk = 1'b0, reset = 1'b1, load = 1'b0, up = 1'b0, down = 1'b0;
  logic [7:0] SW = '0;
  logic [7:0] a_count, b_count, a_AN, b_AN;
  logic [6:0] a_sseg, b_sseg;
  logic       a_busy, b_busy, a_DP, b_DP;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  counter_display_unit #(.BITS(8), .DIGITS(3), .SATURATE(0), .DB_CYCLES(16),
                         .REFRESH(4), .LZB(1)) dut_a (
    .clk(clk), .reset(reset), .load(load), .up(up), .down(down), .SW(SW),
    .count(a_count), .busy(a_busy), .sseg(a_sseg), .AN(a_AN), .DP(a_DP));

  counter_display_unit #(.BITS(8), .DIGITS(3), .SATURATE(1), .DB_CYCLES(16),
                         .REFRESH(4), .LZB(1)) dut_b (
    .clk(clk), .reset(reset), .load(load), .up(up), .down(down), .SW(SW),
    .count(b_count), .busy(b_busy), .sseg(b_sseg), .AN(b_AN), .DP(b_DP));

  typedef struct {
    logic [7:0] sw;
    logic [6:0] s2, s1, s0;
  } vec_t;
  vec_t vecs[7];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic read_display(output logic [6:0] d2, output logic [6:0] d1, output logic [6:0] d0);
    int bad = 0;
    d2 = 'x; d1 = 'x; d0 = 'x;
    for (int i = 0; i < 12; i++) begin
      case (a_AN)
        8'hFE: d0 = a_sseg;
        8'hFD: d1 = a_sseg;
        8'hFB: d2 = a_sseg;
        default: bad++;
      endcase
      tick();
    end
    chk("an_onehot", bad, 0);
  endtask

  task automatic check_scan(input string name);
    logic [7:0] exp;
    for (int i = 0; i < 12; i++) begin
      exp = (i < 4) ? 8'hFE : (i < 8) ? 8'hFD : 8'hFB;
      chk(name, a_AN, exp);
      tick();
    end
  endtask

  task automatic do_load(input logic [7:0] v);
    SW = v; load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  task automatic press(input logic u, input logic d);
    up = u; down = d;
    repeat (40) tick();
    up = 1'b0; down = 1'b0;
    repeat (40) tick();
  endtask

  initial begin
    logic [6:0] d2, d1, d0;
    int seen;

    vecs[0] = '{8'd200, S2, S0, S0};
    vecs[1] = '{8'd7,   SB, SB, S7};
    vecs[2] = '{8'd45,  SB, S4, S5};
    vecs[3] = '{8'd109, S1, S0, S9};
    vecs[4] = '{8'd38,  SB, S3, S8};
    vecs[5] = '{8'd0,   SB, SB, S0};
    vecs[6] = '{8'd255, S2, S5, S5};

    repeat (3) tick();
    chk("rst_count", a_count, 0);
    chk("rst_busy", a_busy, 0);
    chk("rst_an", a_AN, 8'hFE);
    chk("rst_sseg", a_sseg, S0);
    chk("rst_dp", a_DP, 1);
    reset = 1'b0;
    check_scan("scan_seq");

    foreach (vecs[i]) begin
      do_load(vecs[i].sw);
      chk("load_count_a", a_count, vecs[i].sw);
      chk("load_count_b", b_count, vecs[i].sw);
      tick();
      chk("busy_start", a_busy, 1);
      repeat (9) tick();
      chk("busy_end", a_busy, 0);
      read_display(d2, d1, d0);
      chk("digit2", d2, vecs[i].s2);
      chk("digit1", d1, vecs[i].s1);
      chk("digit0", d0, vecs[i].s0);
    end

    // Limits: wrap on A, hold on B
    press(1'b1, 1'b0);
    chk("wrap_up_a", a_count, 0);
    chk("sat_up_b", b_count, 255);
    press(1'b0, 1'b1);
    chk("wrap_dn_a", a_count, 255);
    chk("sat_dn_b", b_count, 254);
    do_load(8'd0);
    press(1'b0, 1'b1);
    chk("wrap_dn0_a", a_count, 255);
    chk("sat_dn0_b", b_count, 0);

    // Bouncing contacts
    do_load(8'd10);
    for (int i = 0; i < 10; i++) begin
      up = ~up;
      repeat (3) tick();
    end
    chk("bounce_none", a_count, 10);
    up = 1'b1;
    repeat (40) tick();
    chk("bounce_one", a_count, 11);
    up = 1'b0;
    repeat (40) tick();
    chk("bounce_rel", a_count, 11);

    // Simultaneous presses cancel
    do_load(8'd20);
    press(1'b1, 1'b1);
    chk("both_a", a_count, 20);
    chk("both_b", b_count, 20);

    // Load overrides a pulse
    SW = 8'd77; load = 1'b1; up = 1'b1;
    tick();
    for (int i = 0; i < 40; i++) begin
      chk("load_pri", a_count, 77);
      tick();
    end
    load = 1'b0;
    up = 1'b0;
    repeat (40) tick();
    chk("load_pri_after", a_count, 77);

    // Count changes mid-conversion
    do_load(8'd5);
    tick();
    tick();
    SW = 8'd6; load = 1'b1;
    tick();
    load = 1'b0;
    chk("mid_count", a_count, 6);
    repeat (6) tick();
    chk("mid_busy_shift", a_busy, 1);
    tick();
    chk("mid_busy_done", a_busy, 0);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (i == 1) chk("mid_busy_restart", a_busy, 1);
      if (a_AN == 8'hFE) begin
        seen++;
        chk("mid_first", a_sseg, S5);
      end
      tick();
    end
    chk("mid_seen", (seen > 0), 1);
    read_display(d2, d1, d0);
    chk("mid_second", {d2, d1, d0}, {SB, SB, S6});

    // Reset aborts an in-flight conversion
    do_load(8'd123);
    repeat (3) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_count", a_count, 0);
    chk("abort_busy", a_busy, 0);
    chk("abort_sseg", a_sseg, S0);
    check_scan("abort_scan");
    repeat (10) tick();
    chk("abort_busy_late", a_busy, 0);
    read_display(d2, d1, d0);
    chk("abort_disp", {d2, d1, d0}, {SB, SB, S0});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, required finish before 200000");
    $fatal(1);
  end

endmodule
